// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared types and constants for the delay-line playback path
package delay_pkg;

  typedef enum logic [2:0] {IDLE, REQ, MUL, ACC, DONE} state_t;

  localparam int Q_FRAC     = 16;
  localparam int MUL_CYCLES = 16;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - sequential unsigned shift-add multiplier, one multiplier bit per cycle
module shift_add_mul
  import delay_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = Q_FRAC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           done,
  output logic [A_W-1:0] p_hi
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic [P_W-1:0]   r_prod;
  logic [P_W-1:0]   r_mcand;
  logic [B_W-1:0]   r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_prod   <= '0;
      r_mcand  <= P_W'(a);
      r_mplier <= b;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (done) r_run <= 1'b0;
    end
  end

  // done marks the final iteration; p_hi is complete on the following cycle
  assign done = r_run && (r_cnt == CNT_W'(MUL_CYCLES - 1));
  assign p_hi = r_prod[B_W +: A_W];

endmodule

// File: rtl/delay_line_reader.sv
// rtl/delay_line_reader.sv - multi-tap delay memory reader with decaying gain and saturating sum
module delay_line_reader
  import delay_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_TAPS = 8,
  parameter int ACC_W    = DATA_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] delay,
  input  logic [3:0]        taps,
  input  logic [Q_FRAC-1:0] gain,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wet_out,
  output logic              wet_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic signed [ACC_W-1:0] L_SAT_MAX  = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] L_SAT_MIN  = ACC_W'(sat_min(DATA_W));
  localparam logic [3:0]              L_MAX_TAPS = 4'(MAX_TAPS);

  state_t                   r_state, w_next;
  logic [ADDR_W-1:0]        r_addr, r_delay;
  logic [Q_FRAC-1:0]        r_coef;
  logic [3:0]               r_left;
  logic                     r_neg;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_mem_rd_req, r_wet_valid, r_busy, r_overrun;
  logic [DATA_W-1:0]        r_wet_out;

  logic                     w_accept, w_mul_done;
  logic [3:0]               w_taps_clamped;
  logic [DATA_W-1:0]        w_mag, w_p_hi, w_sat;
  logic signed [DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;

  assign w_accept       = (r_state == REQ) && mem_ready;
  assign w_taps_clamped = (taps > L_MAX_TAPS) ? L_MAX_TAPS : taps;
  // the most negative sample maps to 2^(DATA_W-1), which still fits unsigned
  assign w_mag          = mem_rdata[DATA_W-1] ? (~mem_rdata + DATA_W'(1)) : mem_rdata;
  assign w_prod         = r_neg ? -$signed(w_p_hi) : $signed(w_p_hi);
  assign w_prod_ext     = {{(ACC_W-DATA_W){w_prod[DATA_W-1]}}, w_prod};
  assign w_sat          = (r_acc > L_SAT_MAX) ? L_SAT_MAX[DATA_W-1:0] :
                          (r_acc < L_SAT_MIN) ? L_SAT_MIN[DATA_W-1:0] :
                          r_acc[DATA_W-1:0];

  shift_add_mul #(.A_W(DATA_W), .B_W(Q_FRAC)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept),
    .a     (w_mag),
    .b     (r_coef),
    .done  (w_mul_done),
    .p_hi  (w_p_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (sample_tick) w_next = (w_taps_clamped == 4'd0) ? DONE : REQ;
      REQ:     if (mem_ready) w_next = MUL;
      MUL:     if (w_mul_done) w_next = ACC;
      ACC:     w_next = (r_left == 4'd1) ? DONE : REQ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_delay      <= '0;
      r_coef       <= '0;
      r_left       <= '0;
      r_neg        <= 1'b0;
      r_acc        <= '0;
      r_mem_rd_req <= 1'b0;
      r_wet_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_wet_out    <= '0;
    end else begin
      // outputs are registered from the next state so they line up with it
      r_mem_rd_req <= (w_next == REQ);
      r_busy       <= (w_next != IDLE);
      r_overrun    <= sample_tick && (r_state != IDLE);
      r_wet_valid  <= (r_state == DONE);
      case (r_state)
        IDLE: if (sample_tick) begin
          r_addr  <= wr_ptr - delay;
          r_delay <= delay;
          r_coef  <= gain;
          r_left  <= w_taps_clamped;
          r_acc   <= '0;
        end
        REQ: if (mem_ready) r_neg <= mem_rdata[DATA_W-1];
        ACC: begin
          r_acc  <= r_acc + w_prod_ext;
          r_addr <= r_addr - r_delay;
          r_coef <= r_coef >> 1;
          r_left <= r_left - 4'd1;
        end
        DONE:    r_wet_out <= w_sat;
        default: ;
      endcase
    end
  end

  assign mem_rd_req = r_mem_rd_req;
  assign mem_addr   = r_addr;
  assign wet_out    = r_wet_out;
  assign wet_valid  = r_wet_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_delay_line_reader.sv
// tb/tb_delay_line_reader.sv - randomized self-checking bench for delay_line_reader
module tb_delay_line_reader;

  logic        clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0;
  logic [15:0] wr_ptr = '0, delay = '0, gain = '0;
  logic [3:0]  taps = '0;
  logic        mem_rd_req, mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_rdata = '0, wet_out;
  logic        wet_valid, busy, overrun;

  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] mem [0:65535];
  int cfg_wait = 0;
  bit cfg_rand = 0;
  int wait_left = 0;
  int req_cyc = 0, ovr_cyc = 0, wv_cnt = 0, stab_bad = 0, waits_used = 0;
  logic [15:0] addr_log[$];
  logic [15:0] exp_addr[$];
  bit prev_stall = 0;
  logic [15:0] prev_addr = '0;

  delay_line_reader dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .wr_ptr(wr_ptr),
    .delay(delay), .taps(taps), .gain(gain), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wet_out(wet_out), .wet_valid(wet_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder and activity monitor
  initial forever begin
    @(negedge clk);
    if (prev_stall && (!mem_rd_req || mem_addr !== prev_addr)) stab_bad++;
    prev_stall = 0;
    if (overrun) ovr_cyc++;
    if (wet_valid) wv_cnt++;
    if (mem_rd_req) begin
      req_cyc++;
      if (wait_left > 0) begin
        mem_ready = 1'b0; wait_left--; waits_used++;
        prev_stall = 1; prev_addr = mem_addr;
      end else begin
        mem_ready = 1'b1; mem_rdata = mem[mem_addr];
        addr_log.push_back(mem_addr);
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      wait_left = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
    end
  end

  task automatic model(input logic [15:0] wr, input logic [15:0] dly, input logic [15:0] g,
                       input logic [3:0] tp, output logic [15:0] out, output int nt);
    longint acc, coef, s, mag, p;
    logic [15:0] a;
    nt = (tp > 4'd8) ? 8 : int'(tp);
    acc = 0; coef = longint'(g); a = wr;
    exp_addr.delete();
    for (int k = 0; k < nt; k++) begin
      a = a - dly;
      exp_addr.push_back(a);
      s = longint'($signed(mem[a]));
      mag = (s < 0) ? -s : s;
      p = (mag * coef) >>> 16;
      acc = acc + ((s < 0) ? -p : p);
      coef = coef >>> 1;
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    out = 16'(acc);
  endtask

  task automatic run_once(input logic [15:0] wr, input logic [15:0] dly, input logic [15:0] g,
                          input logic [3:0] tp, input bit scramble, input int extra_at,
                          output logic [15:0] out, output int lat, output bit to);
    int t0;
    @(negedge clk);
    wr_ptr = wr; delay = dly; gain = g; taps = tp; sample_tick = 1'b1;
    t0 = cyc;
    req_cyc = 0; ovr_cyc = 0; wv_cnt = 0; stab_bad = 0; waits_used = 0;
    addr_log.delete();
    lat = -1; out = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      sample_tick = (extra_at != 0) && (cyc - t0 == extra_at);
      if (scramble) begin
        wr_ptr = 16'($urandom); delay = 16'($urandom); gain = 16'($urandom); taps = 4'($urandom);
      end
      if (wet_valid) begin
        lat = cyc - t0; out = wet_out;
        break;
      end
    end
    sample_tick = 1'b0;
    to = (lat < 0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_rd_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    checks++; if (wet_out !== 16'h0) begin errors++; $display("FAIL reset_wet_out: got %h expected 0000", wet_out); end
    checks++; if (wet_valid !== 1'b0) begin errors++; $display("FAIL reset_wet_valid: got %b expected 0", wet_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_two_taps;
    logic [15:0] wr, d, out;
    int lat;
    bit to;
    wr = 16'($urandom); d = 16'($urandom_range(1, 1000));
    mem[wr - d] = 16'h4000; mem[wr - 16'(2 * d)] = 16'h4000;
    run_once(wr, d, 16'h8000, 4'd2, 1'b0, 0, out, lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL two_taps_timeout: got %b expected 0", to); end
    checks++; if (out !== 16'h3000) begin errors++; $display("FAIL two_taps_out: got %h expected 3000", out); end
    checks++; if (lat !== 38) begin errors++; $display("FAIL two_taps_latency: got %0d expected 38", lat); end
  endtask

  task automatic test_wait_states;
    logic [15:0] wr, d, g, out, exp;
    int lat, nt;
    bit to;
    wr = 16'($urandom); d = 16'($urandom); g = 16'($urandom);
    model(wr, d, g, 4'd1, exp, nt);
    cfg_wait = 3;
    run_once(wr, d, g, 4'd1, 1'b0, 0, out, lat, to);
    cfg_wait = 0;
    checks++; if (out !== exp) begin errors++; $display("FAIL wait_out: got %h expected %h", out, exp); end
    checks++; if (lat !== 23) begin errors++; $display("FAIL wait_latency: got %0d expected 23", lat); end
    checks++; if (req_cyc !== 4) begin errors++; $display("FAIL wait_req_cycles: got %0d expected 4", req_cyc); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL wait_stability: got %0d unstable cycles expected 0", stab_bad); end
  endtask

  task automatic test_wrap_bypass;
    logic [15:0] out, exp;
    int lat, nt;
    bit to;
    model(16'h0002, 16'h0005, 16'h9000, 4'd2, exp, nt);
    run_once(16'h0002, 16'h0005, 16'h9000, 4'd2, 1'b0, 0, out, lat, to);
    checks++; if (addr_log.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 16'hFFFD) begin errors++; $display("FAIL wrap_addr0: got %h expected fffd", addr_log[0]); end
      checks++; if (addr_log[1] !== 16'hFFF8) begin errors++; $display("FAIL wrap_addr1: got %h expected fff8", addr_log[1]); end
    end
    checks++; if (out !== exp) begin errors++; $display("FAIL wrap_out: got %h expected %h", out, exp); end
    run_once(16'($urandom), 16'($urandom), 16'hFFFF, 4'd0, 1'b0, 0, out, lat, to);
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL bypass_out: got %h expected 0000", out); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL bypass_latency: got %0d expected 2", lat); end
    checks++; if (req_cyc !== 0) begin errors++; $display("FAIL bypass_req: got %0d expected 0", req_cyc); end
  endtask

  task automatic test_saturation;
    logic [15:0] wr, d, out;
    int lat;
    bit to;
    wr = 16'($urandom); d = 16'($urandom_range(1, 100));
    for (int k = 1; k <= 8; k++) mem[wr - 16'(k * d)] = 16'h7FFF;
    run_once(wr, d, 16'hFFFF, 4'd8, 1'b0, 0, out, lat, to);
    checks++; if (out !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", out); end
    checks++; if (lat !== 146) begin errors++; $display("FAIL sat_latency: got %0d expected 146", lat); end
    for (int k = 1; k <= 8; k++) mem[wr - 16'(k * d)] = 16'h8000;
    run_once(wr, d, 16'hFFFF, 4'd12, 1'b0, 0, out, lat, to);
    checks++; if (out !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", out); end
    checks++; if (addr_log.size() !== 8) begin errors++; $display("FAIL clamp_taps: got %0d reads expected 8", addr_log.size()); end
  endtask

  task automatic test_overrun;
    logic [15:0] wr, d, g, out, exp;
    int lat, nt;
    bit to;
    wr = 16'($urandom); d = 16'($urandom); g = 16'($urandom);
    model(wr, d, g, 4'd1, exp, nt);
    run_once(wr, d, g, 4'd1, 1'b0, 5, out, lat, to);
    repeat (30) @(negedge clk);
    checks++; if (ovr_cyc !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cyc); end
    checks++; if (wv_cnt !== 1) begin errors++; $display("FAIL overrun_single_valid: got %0d expected 1", wv_cnt); end
    checks++; if (out !== exp) begin errors++; $display("FAIL overrun_out: got %h expected %h", out, exp); end
    checks++; if (lat !== 20) begin errors++; $display("FAIL overrun_latency: got %0d expected 20", lat); end
    checks++; if (wet_out !== exp) begin errors++; $display("FAIL wet_out_hold: got %h expected %h", wet_out, exp); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] wr, d, g, out, exp;
    logic [3:0] tp;
    int lat, nt;
    bit to;
    wr = 16'($urandom); d = 16'($urandom); g = 16'($urandom); tp = 4'($urandom_range(1, 4));
    model(wr, d, g, tp, exp, nt);
    @(negedge clk);
    wr_ptr = wr; delay = d; gain = g; taps = tp; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_rd_req, mem_addr, wet_valid, wet_out, overrun} !== 35'h0) begin
      errors++; $display("FAIL midreset_outputs: got %h expected 0", {mem_rd_req, mem_addr, wet_valid, wet_out, overrun});
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    run_once(wr, d, g, tp, 1'b0, 0, out, lat, to);
    checks++; if (out !== exp) begin errors++; $display("FAIL midreset_after_out: got %h expected %h", out, exp); end
    checks++; if (lat !== 2 + 18 * nt) begin errors++; $display("FAIL midreset_after_latency: got %0d expected %0d", lat, 2 + 18 * nt); end
  endtask

  task automatic test_random;
    logic [15:0] wr, d, g, out, exp;
    logic [3:0] tp;
    int lat, nt;
    bit to;
    cfg_rand = 1;
    for (int r = 0; r < 40; r++) begin
      wr = 16'($urandom); g = 16'($urandom); tp = 4'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      model(wr, d, g, tp, exp, nt);
      run_once(wr, d, g, tp, 1'b1, 0, out, lat, to);
      checks++; if (out !== exp) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", r, out, exp); end
      checks++; if (lat !== 2 + 18 * nt + waits_used) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", r, lat, 2 + 18 * nt + waits_used);
      end
      checks++; if (addr_log.size() !== exp_addr.size()) begin
        errors++; $display("FAIL rand_read_count[%0d]: got %0d expected %0d", r, addr_log.size(), exp_addr.size());
      end else begin
        for (int k = 0; k < exp_addr.size(); k++) begin
          checks++; if (addr_log[k] !== exp_addr[k]) begin
            errors++; $display("FAIL rand_addr[%0d][%0d]: got %h expected %h", r, k, addr_log[k], exp_addr[k]);
          end
        end
      end
      checks++; if (stab_bad !== 0 || ovr_cyc !== 0) begin
        errors++; $display("FAIL rand_req_stable_no_overrun[%0d]: got %0d/%0d expected 0/0", r, stab_bad, ovr_cyc);
      end
    end
    cfg_rand = 0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] wr, d, g, out, exp;
    logic [3:0] tp;
    int lat, nt;
    bit to;
    for (int r = 0; r < 5; r++) begin
      wr = 16'($urandom); d = 16'($urandom); g = 16'($urandom); tp = 4'($urandom_range(1, 3));
      model(wr, d, g, tp, exp, nt);
      run_once(wr, d, g, tp, 1'b0, 0, out, lat, to);
      checks++; if (out !== exp) begin errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", r, out, exp); end
      checks++; if (ovr_cyc !== 0 || lat !== 2 + 18 * nt) begin
        errors++; $display("FAIL b2b_timing[%0d]: got overrun %0d latency %0d expected 0 and %0d", r, ovr_cyc, lat, 2 + 18 * nt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset;
    test_two_taps;
    test_wait_states;
    test_wrap_bypass;
    test_saturation;
    test_overrun;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
